// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
//   It decodes hex nibbles to active-low cathodes. It also provides a
//   per-digit decimal point, leading-zero blanking, per-digit blink and
//   PWM brightness.
//   Values are double-buffered: a load writes the shadow registers, and the
//   shadow is copied to the active registers only at a frame boundary.
// Ports
//   clk_in       system clock
//   rst_n_in     asynchronous reset, active-low
//   val_in       hex value, digit i = val_in[4i+3:4i], digit 0 rightmost
//   dp_in        decimal point enable per digit (1 = lit)
//   blink_in     per-digit blink enable
//   blank_lz_in  leading-zero suppression, used live
//   bright_in    brightness code, used live
//   load_in      capture val_in/dp_in/blink_in into the shadow registers
//   cat_out      cathodes {g,f,e,d,c,b,a}, active-low
//   dp_out       decimal point cathode, active-low
//   an_out       anodes, active-low, at most one low
//   frame_out    one-cycle pulse at each frame boundary
module seven_segment_scanner #(
   parameter int NUM_DIGITS   = 8,
   parameter int COUNT_TO     = 100_000,
   parameter int PWM_BITS     = 4,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic [4*NUM_DIGITS-1:0]   val_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blink_in,
   input  logic                      blank_lz_in,
   input  logic [PWM_BITS-1:0]       bright_in,
   input  logic                      load_in,
   output logic [6:0]                cat_out,
   output logic                      dp_out,
   output logic [NUM_DIGITS-1:0]     an_out,
   output logic                      frame_out
);

   localparam int SLOT_W = $clog2(COUNT_TO + 1);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(COUNT_TO);
   localparam logic [IDX_W-1:0]  DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0]  FRAME_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [SLOT_W-1:0]       slot_cnt;
   logic [IDX_W-1:0]        digit_idx;
   logic [PWM_BITS-1:0]     pwm_cnt;
   logic [FRM_W-1:0]        frame_cnt;
   logic                    blink_phase;

   logic [4*NUM_DIGITS-1:0] shadow_val, act_val;
   logic [NUM_DIGITS-1:0]   shadow_dp, act_dp;
   logic [NUM_DIGITS-1:0]   shadow_blink, act_blink;

   logic [NUM_DIGITS-1:0]   lz_zero;
   logic [3:0]              cur_nib;
   logic                    cur_dp, cur_blink, cur_lz;
   logic                    blank, lit;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   // lz_zero[i]: nibbles i..NUM_DIGITS-1 of the active value are all zero
   always_comb begin
      lz_zero = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         lz_zero[i] = ((act_val >> (4 * i)) == '0);
      end
   end

   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      cur_lz    = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            cur_nib   = act_val[4*i +: 4];
            cur_dp    = act_dp[i];
            cur_blink = act_blink[i];
            cur_lz    = lz_zero[i];
         end
      end
   end

   always_comb begin
      blank = (blink_phase && cur_blink) ||
              (blank_lz_in && (digit_idx != '0) && cur_lz);
      lit   = (pwm_cnt <= bright_in) && !blank;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         slot_cnt     <= '0;
         digit_idx    <= '0;
         pwm_cnt      <= '0;
         frame_cnt    <= '0;
         blink_phase  <= 1'b0;
         shadow_val   <= '0;
         shadow_dp    <= '0;
         shadow_blink <= '0;
         act_val      <= '0;
         act_dp       <= '0;
         act_blink    <= '0;
         an_out       <= '1;
         cat_out      <= '1;
         dp_out       <= 1'b1;
         frame_out    <= 1'b0;
      end else begin
         pwm_cnt   <= pwm_cnt + 1'b1;
         frame_out <= 1'b0;

         if (load_in) begin
            shadow_val   <= val_in;
            shadow_dp    <= dp_in;
            shadow_blink <= blink_in;
         end

         if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            if (digit_idx == DIGIT_LAST) begin
               // Frame boundary. Active takes the shadow contents from before
               // this edge, so a coincident load shows from the next frame.
               digit_idx <= '0;
               frame_out <= 1'b1;
               act_val   <= shadow_val;
               act_dp    <= shadow_dp;
               act_blink <= shadow_blink;
               if (frame_cnt == FRAME_LAST) begin
                  frame_cnt   <= '0;
                  blink_phase <= ~blink_phase;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end else begin
               digit_idx <= digit_idx + 1'b1;
            end
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end

         // Outputs follow the index/PWM state of the previous cycle
         if (lit) begin
            an_out  <= ~(NUM_DIGITS'(1) << digit_idx);
            cat_out <= seg_decode(cur_nib);
            dp_out  <= ~cur_dp;
         end else begin
            an_out  <= '1;
            cat_out <= '1;
            dp_out  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Directed bench for seven_segment_scanner with COUNT_TO=3, NUM_DIGITS=8,
//   PWM_BITS=4 and BLINK_FRAMES=2. A frame is 32 cycles, and each digit
//   slot is 4 cycles.
module tb_seven_segment_scanner;

   logic        clk_in = 1'b0;
   logic        clk_run = 1'b1;
   logic        rst_n_in;
   logic [31:0] val_in;
   logic [7:0]  dp_in;
   logic [7:0]  blink_in;
   logic        blank_lz_in;
   logic [3:0]  bright_in;
   logic        load_in;
   logic [6:0]  cat_out;
   logic        dp_out;
   logic [7:0]  an_out;
   logic        frame_out;

   int tests = 0;
   int fails = 0;
   int frames;

   seven_segment_scanner #(
      .NUM_DIGITS(8),
      .COUNT_TO(3),
      .PWM_BITS(4),
      .BLINK_FRAMES(2)
   ) dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .val_in(val_in),
      .dp_in(dp_in),
      .blink_in(blink_in),
      .blank_lz_in(blank_lz_in),
      .bright_in(bright_in),
      .load_in(load_in),
      .cat_out(cat_out),
      .dp_out(dp_out),
      .an_out(an_out),
      .frame_out(frame_out)
   );

   always begin
      #5;
      if (clk_run) clk_in = ~clk_in;
   end

   // Frame boundaries seen since reset; blink phase is (frames/2) mod 2
   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) frames <= 0;
      else if (frame_out) frames <= frames + 1;
   end

   typedef struct {
      logic [31:0] val;
      logic [7:0]  dp;
      logic        lz;
      int          digit;
      logic [7:0]  an;
      logic [6:0]  cat;
      logic        dpo;
   } vec_t;

   vec_t vecs[26];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_frame();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk_in);
         if (frame_out) seen = 1'b1;
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL frame_timeout: got no frame_out, expected one within 200 cycles");
      end
   endtask

   task automatic load_vals(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b);
      @(negedge clk_in);
      val_in   = v;
      dp_in    = d;
      blink_in = b;
      load_in  = 1'b1;
      @(negedge clk_in);
      load_in  = 1'b0;
   endtask

   initial begin
      int cnt;
      bit onehot_ok;
      bit dark;
      logic [3:0] br_tab[4];
      int         on_tab[4];

      vecs[0]  = '{32'h01234567, 8'h00, 1'b0, 0, 8'hFE, 7'h78, 1'b1};
      vecs[1]  = '{32'h01234567, 8'h00, 1'b0, 1, 8'hFD, 7'h02, 1'b1};
      vecs[2]  = '{32'h01234567, 8'h00, 1'b0, 2, 8'hFB, 7'h12, 1'b1};
      vecs[3]  = '{32'h01234567, 8'h04, 1'b0, 2, 8'hFB, 7'h12, 1'b0};
      vecs[4]  = '{32'h01234567, 8'h00, 1'b0, 3, 8'hF7, 7'h19, 1'b1};
      vecs[5]  = '{32'h01234567, 8'h00, 1'b0, 4, 8'hEF, 7'h30, 1'b1};
      vecs[6]  = '{32'h01234567, 8'h00, 1'b0, 5, 8'hDF, 7'h24, 1'b1};
      vecs[7]  = '{32'h01234567, 8'h00, 1'b0, 6, 8'hBF, 7'h79, 1'b1};
      vecs[8]  = '{32'h01234567, 8'h00, 1'b0, 7, 8'h7F, 7'h40, 1'b1};
      vecs[9]  = '{32'hFEDCBA98, 8'h00, 1'b0, 0, 8'hFE, 7'h00, 1'b1};
      vecs[10] = '{32'hFEDCBA98, 8'h00, 1'b0, 1, 8'hFD, 7'h10, 1'b1};
      vecs[11] = '{32'hFEDCBA98, 8'h00, 1'b0, 2, 8'hFB, 7'h08, 1'b1};
      vecs[12] = '{32'hFEDCBA98, 8'h00, 1'b0, 3, 8'hF7, 7'h03, 1'b1};
      vecs[13] = '{32'hFEDCBA98, 8'h00, 1'b0, 4, 8'hEF, 7'h46, 1'b1};
      vecs[14] = '{32'hFEDCBA98, 8'h00, 1'b0, 5, 8'hDF, 7'h21, 1'b1};
      vecs[15] = '{32'hFEDCBA98, 8'h00, 1'b0, 6, 8'hBF, 7'h06, 1'b1};
      vecs[16] = '{32'hFEDCBA98, 8'h00, 1'b0, 7, 8'h7F, 7'h0E, 1'b1};
      vecs[17] = '{32'h000000A0, 8'h00, 1'b1, 0, 8'hFE, 7'h40, 1'b1};
      vecs[18] = '{32'h000000A0, 8'h00, 1'b1, 1, 8'hFD, 7'h08, 1'b1};
      vecs[19] = '{32'h000000A0, 8'h00, 1'b1, 2, 8'hFF, 7'h7F, 1'b1};
      vecs[20] = '{32'h000000A0, 8'h00, 1'b1, 7, 8'hFF, 7'h7F, 1'b1};
      vecs[21] = '{32'h00000005, 8'h02, 1'b1, 1, 8'hFF, 7'h7F, 1'b1};
      vecs[22] = '{32'h00000000, 8'h01, 1'b1, 0, 8'hFE, 7'h40, 1'b0};
      vecs[23] = '{32'h00100000, 8'h00, 1'b1, 3, 8'hF7, 7'h40, 1'b1};
      vecs[24] = '{32'h00100000, 8'h00, 1'b1, 6, 8'hFF, 7'h7F, 1'b1};
      vecs[25] = '{32'h01234567, 8'h00, 1'b1, 7, 8'hFF, 7'h7F, 1'b1};

      br_tab = '{4'hF, 4'h3, 4'h0, 4'h7};
      on_tab = '{16, 4, 1, 8};

      rst_n_in    = 1'b0;
      val_in      = '0;
      dp_in       = '0;
      blink_in    = '0;
      blank_lz_in = 1'b0;
      bright_in   = 4'hF;
      load_in     = 1'b0;

      // Reset state
      repeat (3) @(negedge clk_in);
      check("rst_an", 32'(an_out), 32'hFF);
      check("rst_cat", 32'(cat_out), 32'h7F);
      check("rst_dp", 32'(dp_out), 32'h1);
      check("rst_frame", 32'(frame_out), 32'h0);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      check("first_an", 32'(an_out), 32'hFE);
      check("first_cat", 32'(cat_out), 32'h40);

      // Table: load, let two boundaries pass, then look at the chosen digit
      for (int i = 0; i < 26; i++) begin
         blank_lz_in = vecs[i].lz;
         load_vals(vecs[i].val, vecs[i].dp, 8'h00);
         wait_frame();
         wait_frame();
         repeat (1 + 4 * vecs[i].digit) @(negedge clk_in);
         check($sformatf("vec%0d_an", i), 32'(an_out), 32'(vecs[i].an));
         check($sformatf("vec%0d_cat", i), 32'(cat_out), 32'(vecs[i].cat));
         check($sformatf("vec%0d_dp", i), 32'(dp_out), 32'(vecs[i].dpo));
      end

      // Digit 0 slot length: exactly 4 cycles lit, then digit 1
      blank_lz_in = 1'b0;
      load_vals(32'h01234567, 8'h00, 8'h00);
      wait_frame();
      wait_frame();
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_in);
         if (an_out == 8'hFE && cat_out == 7'h78) cnt++;
      end
      check("slot_len", 32'(cnt), 32'd4);
      check("slot_next_an", 32'(an_out), 32'hFD);
      check("slot_next_cat", 32'(cat_out), 32'h02);

      // Mid-frame load holds off until the frame boundary
      wait_frame();
      @(negedge clk_in);
      check("mid_pre_cat", 32'(cat_out), 32'h78);
      val_in  = 32'h0;
      load_in = 1'b1;
      @(negedge clk_in);
      load_in = 1'b0;
      repeat (11) @(negedge clk_in);
      check("mid_hold_an", 32'(an_out), 32'hF7);
      check("mid_hold_cat", 32'(cat_out), 32'h19);
      wait_frame();
      @(negedge clk_in);
      check("mid_post_an", 32'(an_out), 32'hFE);
      check("mid_post_cat", 32'(cat_out), 32'h40);

      // Load coinciding with the boundary: previous shadow shows first
      wait_frame();
      val_in  = 32'h01234567;
      load_in = 1'b1;
      @(negedge clk_in);
      load_in = 1'b0;
      repeat (30) @(negedge clk_in);
      val_in  = 32'h00000003;
      load_in = 1'b1;
      @(negedge clk_in);
      load_in = 1'b0;
      check("coin_frame", 32'(frame_out), 32'h1);
      @(negedge clk_in);
      check("coin_old_cat", 32'(cat_out), 32'h78);
      wait_frame();
      @(negedge clk_in);
      check("coin_new_cat", 32'(cat_out), 32'h30);

      // PWM duty over any 16 consecutive cycles
      onehot_ok = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk_in);
         bright_in = br_tab[b];
         cnt = 0;
         for (int k = 0; k < 16; k++) begin
            @(negedge clk_in);
            if (an_out != 8'hFF) cnt++;
            if ($countones(~an_out) > 1) onehot_ok = 1'b0;
         end
         check($sformatf("pwm_on_b%0h", br_tab[b]), 32'(cnt), 32'(on_tab[b]));
      end
      check("an_onehot", 32'(onehot_ok), 32'h1);
      bright_in = 4'hF;

      // Blink on digit 0, decimal point follows it
      load_vals(32'h01234567, 8'h01, 8'h01);
      wait_frame();
      wait_frame();
      for (int f = 0; f < 8; f++) begin
         wait_frame();
         @(negedge clk_in);
         dark = ((frames / 2) % 2) == 1;
         check($sformatf("blink%0d_an0", f), 32'(an_out[0]), 32'(dark));
         check($sformatf("blink%0d_dp", f), 32'(dp_out), 32'(dark));
      end

      // Asynchronous reset mid-scan with the clock stopped
      wait_frame();
      repeat (5) @(negedge clk_in);
      clk_run = 1'b0;
      #2;
      rst_n_in = 1'b0;
      #1;
      check("async_an", 32'(an_out), 32'hFF);
      check("async_cat", 32'(cat_out), 32'h7F);
      check("async_dp", 32'(dp_out), 32'h1);
      check("async_frame", 32'(frame_out), 32'h0);
      #10;
      rst_n_in = 1'b1;
      blink_in = '0;
      #3;
      clk_run = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk_in);
         if (k == 1) begin
            check("restart_an", 32'(an_out), 32'hFE);
            check("restart_cat", 32'(cat_out), 32'h40);
         end
         if (frame_out) begin
            cnt = k;
            break;
         end
      end
      check("restart_frame_lat", 32'(cnt), 32'd32);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
